fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//   Parametrised forwarding/hazard unit for the 5-stage MIPS pipeline; sits beside ID stage.
//   Generalises to NUM_RD read ports and NUM_FWD producer stages, emitting one bypass select per port.
//   Adds sequential tracking of the multi-cycle divider (HI/LO busy countdown) and load-use stall.
//   Drives PC/IR write enables and the ID->EXE bubble.
// PARAMETERS
//   NUM_RD   2   ID read ports (rs, rt, ...)
//   NUM_FWD  3   producer stages, index 0 = EXE (youngest), 1 = MEM, 2 = WB
//   AW       5   register address width
//   WEW      4   byte-write-enable width per producer
//   DIV_LAT  33  divider occupancy in cycles after issue (1..255)
// PORTS
//   clk            in   1             clock, rising edge
//   rst_n          in   1             asynchronous, active-low reset
//   rd_en          in   NUM_RD        port i really reads its register
//   rd_addr        in   NUM_RD*AW     read addresses, port i at [i*AW +: AW]
//   stg_waddr      in   NUM_FWD*AW    destination per producer stage
//   stg_wen        in   NUM_FWD*WEW   byte write enables per producer stage
//   stg_load       in   NUM_FWD       producer result not yet available (load in flight)
//   hilo_rd        in   1             ID instr reads HI/LO (MFHI/MFLO)
//   div_start      in   1             ID instr is DIV/DIVU
//   ex_flush       in   1             exception/interrupt flush this cycle
//   fwd_sel        out  NUM_RD*SELW   SELW=$clog2(NUM_FWD+1); 0=regfile, k=stage k-1
//   id_stall       out  1             hold PC/IR, bubble into ID/EXE
//   pc_write       out  1             ~id_stall
//   ir_write       out  1             ~id_stall
//   div_busy       out  1             divider countdown nonzero
// BEHAVIOUR
//   - Match(i,k): rd_en[i] & rd_addr[i]!=0 & rd_addr[i]==stg_waddr[k] & |stg_wen[k].
//   - fwd_sel[i] = 1 + lowest k with Match(i,k) (youngest wins), else 0. Purely combinational.
//   - load_haz = any i with selected stage k having stg_load[k]=1 (only the winning stage counts).
//   - div_cnt (8b): reset 0. If div_start & ~id_stall & ~ex_flush: load DIV_LAT.
//     Else if nonzero: decrement by 1 per cycle. Never wraps below 0. div_busy = |div_cnt.
//   - div_haz = div_busy & (hilo_rd | div_start).
//   - id_stall = (load_haz | div_haz) & ~ex_flush, forced 0 while rst_n low.
//   - ex_flush does not clear div_cnt (issued divide completes); it only blocks a new load.
//   - div_start while stalled is not accepted; re-evaluated each cycle until accepted.
//   - Reset (any time, incl. mid-divide): div_cnt=0, div_busy=0, id_stall=0, pc_write=ir_write=1,
//     perf counters 0. Latency: fwd_sel/id_stall 0 cycles; div_busy rises the cycle after issue.
// CONFIGURATION
//   HAZ_PERF_EN defined: adds outputs load_stall_cnt[31:0], div_stall_cnt[31:0]; each
//     increments (wrapping) on cycles where id_stall=1 due to load_haz / div_haz
//     (both if both); cleared by reset only.
//   HAZ_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//   haz_pkg: SELW function, FWD_SEL_RF=0 constant, DIV_CNT_W=8, stage index constants.
//   Sub-module haz_port_match: one read port vs all stages -> sel + load flag; generate NUM_RD copies.
//   Top holds div countdown, stall combine and optional perf counters.
// TESTING
//   T1 rd_addr[0]=5, stg_waddr={EXE:5,MEM:5}, wen=4'hF, no loads -> fwd_sel[0]=1, id_stall=0.
//   T2 rd_addr[1]=0 matching stage waddr 0 with wen=4'hF -> fwd_sel[1]=0 (r0 never bypassed).
//   T3 EXE load to r8 (stg_load[0]=1), rd_addr[0]=8 -> id_stall=1, pc_write=0; next cycle load in
//      MEM with stg_load[1]=0 -> fwd_sel[0]=2, id_stall=0.
//   T4 div_start with DIV_LAT=33 -> div_busy high 33 cycles; hilo_rd during window -> stall;
//      hilo_rd on cycle after div_busy falls -> no stall.
//   T5 ex_flush=1 with load_haz=1 -> id_stall=0; div_start with ex_flush -> div_cnt stays 0.
//   T6 rst_n low mid-divide (div_cnt=17) -> div_busy=0 immediately; with HAZ_PERF_EN, after
//      4 load-stall cycles load_stall_cnt=4, div_stall_cnt=0.

Source files
------------

// File: rtl/haz_pkg.sv
// Shared constants and helpers for the forwarding/hazard unit.
// Stage indices follow producer order: EXE is youngest.
package haz_pkg;

  typedef enum int {
    STG_EXE = 0,
    STG_MEM = 1,
    STG_WB  = 2
  } stage_e;

  localparam int FWD_SEL_RF = 0;
  localparam int DIV_CNT_W  = 8;

  function automatic int sel_w(input int num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/haz_port_match.sv
// One ID read port compared against every producer stage.
// Youngest matching stage wins; load_hit flags a winner still in flight.
module haz_port_match
  import haz_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int AW      = 5,
  parameter int WEW     = 4,
  parameter int SELW    = 2
) (
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  input  logic [NUM_FWD*AW-1:0]  stg_waddr,
  input  logic [NUM_FWD*WEW-1:0] stg_wen,
  input  logic [NUM_FWD-1:0]     stg_load,
  output logic [SELW-1:0]        sel,
  output logic                   load_hit
);

  logic use_port;

  assign use_port = rd_en & (rd_addr != '0);

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel      = SELW'(FWD_SEL_RF);
    load_hit = 1'b0;
    for (int k = NUM_FWD - 1; k >= int'(STG_EXE); k--) begin
      if (use_port &&
          rd_addr == stg_waddr[k*AW +: AW] &&
          |stg_wen[k*WEW +: WEW]) begin
        sel      = SELW'(k + 1);
        load_hit = stg_load[k];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects, load-use and divider hazard stalls beside ID.
// Define HAZ_PERF_EN to add load/div stall cycle counters.
module fwd_hazard_unit
  import haz_pkg::*;
#(
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = int'(STG_WB) + 1,
  parameter int AW      = 5,
  parameter int WEW     = 4,
  parameter int DIV_LAT = 33
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD-1:0]      rd_en,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  input  logic [NUM_FWD*AW-1:0]  stg_waddr,
  input  logic [NUM_FWD*WEW-1:0] stg_wen,
  input  logic [NUM_FWD-1:0]     stg_load,
  input  logic                   hilo_rd,
  input  logic                   div_start,
  input  logic                   ex_flush,
  output logic [NUM_RD*sel_w(NUM_FWD)-1:0] fwd_sel,
  output logic                   id_stall,
  output logic                   pc_write,
  output logic                   ir_write,
  output logic                   div_busy
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]            load_stall_cnt,
  output logic [31:0]            div_stall_cnt
`endif
);

  localparam int SELW = sel_w(NUM_FWD);

  logic [NUM_RD-1:0]    port_load;
  logic [DIV_CNT_W-1:0] div_cnt;
  logic                 load_haz;
  logic                 div_haz;
  logic                 div_go;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    haz_port_match #(
      .NUM_FWD (NUM_FWD),
      .AW      (AW),
      .WEW     (WEW),
      .SELW    (SELW)
    ) u_match (
      .rd_en     (rd_en[i]),
      .rd_addr   (rd_addr[i*AW +: AW]),
      .stg_waddr (stg_waddr),
      .stg_wen   (stg_wen),
      .stg_load  (stg_load),
      .sel       (fwd_sel[i*SELW +: SELW]),
      .load_hit  (port_load[i])
    );
  end

  assign load_haz = |port_load;
  assign div_busy = |div_cnt;
  assign div_haz  = div_busy & (hilo_rd | div_start);
  assign id_stall = rst_n & ~ex_flush & (load_haz | div_haz);
  assign pc_write = ~id_stall;
  assign ir_write = ~id_stall;

  // A flush only blocks a new issue; a divide already running completes.
  assign div_go = div_start & ~id_stall & ~ex_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_go) begin
      div_cnt <= DIV_CNT_W'(DIV_LAT);
    end else if (div_busy) begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_stall_cnt <= '0;
      div_stall_cnt  <= '0;
    end else begin
      if (id_stall && load_haz) load_stall_cnt <= load_stall_cnt + 1'b1;
      if (id_stall && div_haz)  div_stall_cnt  <= div_stall_cnt + 1'b1;
    end
  end
`else
  // No stall counters in the default build.
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomised and directed bench for fwd_hazard_unit.
// Reference tracks divider occupancy as an absolute end cycle.
module tb_fwd_hazard_unit;
  import haz_pkg::*;

  localparam int NUM_RD  = 2;
  localparam int NUM_FWD = 3;
  localparam int AW      = 5;
  localparam int WEW     = 4;
  localparam int DIV_LAT = 33;
  localparam int SELW    = 2;

  logic                   clk;
  logic                   rst_n;
  logic [NUM_RD-1:0]      rd_en;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_FWD*AW-1:0]  stg_waddr;
  logic [NUM_FWD*WEW-1:0] stg_wen;
  logic [NUM_FWD-1:0]     stg_load;
  logic                   hilo_rd;
  logic                   div_start;
  logic                   ex_flush;
  logic [NUM_RD*SELW-1:0] fwd_sel;
  logic                   id_stall;
  logic                   pc_write;
  logic                   ir_write;
  logic                   div_busy;
`ifdef HAZ_PERF_EN
  logic [31:0]            load_stall_cnt;
  logic [31:0]            div_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_until = -1;
  int pl = 0;
  int pd = 0;

  fwd_hazard_unit #(
    .NUM_RD  (NUM_RD),
    .NUM_FWD (NUM_FWD),
    .AW      (AW),
    .WEW     (WEW),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .stg_waddr (stg_waddr),
    .stg_wen   (stg_wen),
    .stg_load  (stg_load),
    .hilo_rd   (hilo_rd),
    .div_start (div_start),
    .ex_flush  (ex_flush),
    .fwd_sel   (fwd_sel),
    .id_stall  (id_stall),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .div_busy  (div_busy)
`ifdef HAZ_PERF_EN
    ,
    .load_stall_cnt (load_stall_cnt),
    .div_stall_cnt  (div_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- reference model ----
  function automatic int m_sel(input int i);
    logic [AW-1:0] a;
    a = rd_addr[i*AW +: AW];
    if (!rd_en[i] || a == 0) return 0;
    for (int k = 0; k < NUM_FWD; k++)
      if (a == stg_waddr[k*AW +: AW] && stg_wen[k*WEW +: WEW] != 0)
        return k + 1;
    return 0;
  endfunction

  function automatic bit m_busy();
    return cyc <= busy_until;
  endfunction

  function automatic bit m_load_haz();
    for (int i = 0; i < NUM_RD; i++) begin
      int s;
      s = m_sel(i);
      if (s != 0 && stg_load[s-1]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_div_haz();
    return m_busy() && (hilo_rd || div_start);
  endfunction

  function automatic bit m_stall();
    return rst_n && !ex_flush && (m_load_haz() || m_div_haz());
  endfunction

  task automatic tick();
    bit acc, ls, ds;
    acc = rst_n && div_start && !m_stall() && !ex_flush;
    ls  = m_stall() && m_load_haz();
    ds  = m_stall() && m_div_haz();
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      busy_until = -1;
      pl = 0;
      pd = 0;
    end else begin
      if (acc) busy_until = cyc + DIV_LAT - 1;
      if (ls) pl++;
      if (ds) pd++;
    end
    #1;
  endtask

  task automatic clr();
    rd_en = '0; rd_addr = '0; stg_waddr = '0; stg_wen = '0;
    stg_load = '0; hilo_rd = 0; div_start = 0; ex_flush = 0;
  endtask

  task automatic set_rd(input int i, input logic en, input logic [AW-1:0] a);
    rd_en[i] = en;
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic set_stg(input int k, input logic [AW-1:0] a,
                         input logic [WEW-1:0] w, input logic ld);
    stg_waddr[k*AW +: AW] = a;
    stg_wen[k*WEW +: WEW] = w;
    stg_load[k] = ld;
  endtask

  // ---- tests ----
  task automatic test_reset();
    clr();
    rst_n = 0;
    set_rd(0, 1, 5'd8);
    set_stg(int'(STG_EXE), 5'd8, 4'hF, 1);
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", id_stall); end
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL reset_pcw got=%b exp=1", pc_write); end
    total++; if (ir_write !== 1'b1) begin bad++; $display("FAIL reset_irw got=%b exp=1", ir_write); end
    total++; if (div_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", div_busy); end
`ifdef HAZ_PERF_EN
    total++; if (load_stall_cnt !== 0) begin bad++; $display("FAIL reset_lcnt got=%0d exp=0", load_stall_cnt); end
`endif
    tick(); tick();
    clr();
    rst_n = 1;
    tick();
  endtask

  task automatic test_fwd_basic();
    clr();
    set_rd(0, 1, 5'd5);
    set_stg(int'(STG_EXE), 5'd5, 4'hF, 0);
    set_stg(int'(STG_MEM), 5'd5, 4'hF, 0);
    #1;
    total++; if (fwd_sel[0 +: SELW] !== 2'd1) begin bad++; $display("FAIL t1_sel got=%0d exp=1", fwd_sel[0 +: SELW]); end
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL t1_stall got=%b exp=0", id_stall); end
    set_stg(int'(STG_EXE), 5'd5, 4'h0, 0);
    set_stg(int'(STG_WB), 5'd5, 4'h1, 0);
    #1;
    total++; if (fwd_sel[0 +: SELW] !== 2'd2) begin bad++; $display("FAIL t1_nowen got=%0d exp=2", fwd_sel[0 +: SELW]); end
    set_rd(0, 0, 5'd5);
    #1;
    total++; if (fwd_sel[0 +: SELW] !== 2'd0) begin bad++; $display("FAIL t1_noen got=%0d exp=0", fwd_sel[0 +: SELW]); end
    tick();
  endtask

  task automatic test_r0();
    clr();
    set_rd(1, 1, 5'd0);
    set_stg(int'(STG_EXE), 5'd0, 4'hF, 1);
    #1;
    total++; if (fwd_sel[SELW +: SELW] !== 2'd0) begin bad++; $display("FAIL t2_r0 got=%0d exp=0", fwd_sel[SELW +: SELW]); end
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL t2_stall got=%b exp=0", id_stall); end
    tick();
  endtask

  task automatic test_load_use();
    clr();
    set_rd(0, 1, 5'd8);
    set_stg(int'(STG_EXE), 5'd8, 4'hF, 1);
    #1;
    total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL t3_stall got=%b exp=1", id_stall); end
    total++; if (pc_write !== 1'b0) begin bad++; $display("FAIL t3_pcw got=%b exp=0", pc_write); end
    tick();
    set_stg(int'(STG_EXE), 5'd0, 4'h0, 0);
    set_stg(int'(STG_MEM), 5'd8, 4'hF, 0);
    #1;
    total++; if (fwd_sel[0 +: SELW] !== 2'd2) begin bad++; $display("FAIL t3_sel got=%0d exp=2", fwd_sel[0 +: SELW]); end
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL t3_nostall got=%b exp=0", id_stall); end
    // Older load shadowed by a non-load EXE producer must not stall.
    set_stg(int'(STG_EXE), 5'd8, 4'hF, 0);
    set_stg(int'(STG_MEM), 5'd8, 4'hF, 1);
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL t3_shadow got=%b exp=0", id_stall); end
    tick();
  endtask

  task automatic test_div();
    int nbusy = 0, nstall = 0;
    clr();
    div_start = 1;
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL t4_issue got=%b exp=0", id_stall); end
    total++; if (div_busy !== 1'b0) begin bad++; $display("FAIL t4_pre got=%b exp=0", div_busy); end
    tick();
    div_start = 0;
    hilo_rd = 1;
    for (int i = 0; i < DIV_LAT; i++) begin
      #1;
      if (div_busy === 1'b1) nbusy++;
      if (id_stall === 1'b1) nstall++;
      tick();
    end
    total++; if (nbusy != DIV_LAT) begin bad++; $display("FAIL t4_busy got=%0d exp=%0d", nbusy, DIV_LAT); end
    total++; if (nstall != DIV_LAT) begin bad++; $display("FAIL t4_hilo got=%0d exp=%0d", nstall, DIV_LAT); end
    #1;
    total++; if (div_busy !== 1'b0) begin bad++; $display("FAIL t4_end got=%b exp=0", div_busy); end
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL t4_after got=%b exp=0", id_stall); end
    tick();
  endtask

  task automatic test_flush();
    clr();
    set_rd(0, 1, 5'd3);
    set_stg(int'(STG_EXE), 5'd3, 4'hF, 1);
    ex_flush = 1;
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL t5_flush got=%b exp=0", id_stall); end
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL t5_pcw got=%b exp=1", pc_write); end
    div_start = 1;
    tick();
    total++; if (div_busy !== 1'b0) begin bad++; $display("FAIL t5_divflush got=%b exp=0", div_busy); end
    // Stalled divide is not accepted.
    ex_flush = 0;
    tick();
    total++; if (div_busy !== 1'b0) begin bad++; $display("FAIL t5_divstall got=%b exp=0", div_busy); end
    clr();
    tick();
  endtask

  task automatic test_reset_mid_div();
    clr();
    div_start = 1;
    tick();
    div_start = 0;
    for (int i = 0; i < DIV_LAT - 17; i++) tick();
    total++; if (div_busy !== 1'b1) begin bad++; $display("FAIL t6_busy got=%b exp=1", div_busy); end
    rst_n = 0;
    #1;
    total++; if (div_busy !== 1'b0) begin bad++; $display("FAIL t6_rst got=%b exp=0", div_busy); end
    tick();
    rst_n = 1;
    #1;
    total++; if (div_busy !== 1'b0) begin bad++; $display("FAIL t6_post got=%b exp=0", div_busy); end
    set_rd(1, 1, 5'd9);
    set_stg(int'(STG_MEM), 5'd9, 4'h3, 1);
    for (int i = 0; i < 4; i++) tick();
    clr();
    #1;
`ifdef HAZ_PERF_EN
    total++; if (load_stall_cnt !== 32'd4) begin bad++; $display("FAIL t6_lcnt got=%0d exp=4", load_stall_cnt); end
    total++; if (div_stall_cnt !== 32'd0) begin bad++; $display("FAIL t6_dcnt got=%0d exp=0", div_stall_cnt); end
`endif
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NUM_RD; i++)
        set_rd(i, 1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 3)));
      for (int k = 0; k < NUM_FWD; k++)
        set_stg(k, AW'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0) ? '0 : WEW'($urandom),
                1'($urandom_range(0, 3) == 0));
      hilo_rd   = ($urandom_range(0, 3) == 0);
      div_start = ($urandom_range(0, 15) == 0);
      ex_flush  = ($urandom_range(0, 7) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      #1;
      for (int i = 0; i < NUM_RD; i++) begin
        total++;
        if (fwd_sel[i*SELW +: SELW] !== SELW'(m_sel(i))) begin
          bad++;
          $display("FAIL rnd_sel%0d cyc=%0d got=%0d exp=%0d", i, cyc, fwd_sel[i*SELW +: SELW], m_sel(i));
        end
      end
      total++; if (id_stall !== m_stall()) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, id_stall, m_stall()); end
      total++; if (pc_write !== !m_stall()) begin bad++; $display("FAIL rnd_pcw cyc=%0d got=%b exp=%b", cyc, pc_write, !m_stall()); end
      total++; if (ir_write !== !m_stall()) begin bad++; $display("FAIL rnd_irw cyc=%0d got=%b exp=%b", cyc, ir_write, !m_stall()); end
      total++; if (div_busy !== (rst_n && m_busy())) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, div_busy, rst_n && m_busy()); end
`ifdef HAZ_PERF_EN
      if (rst_n) begin
        total++; if (load_stall_cnt !== 32'(pl)) begin bad++; $display("FAIL rnd_lcnt got=%0d exp=%0d", load_stall_cnt, pl); end
        total++; if (div_stall_cnt !== 32'(pd)) begin bad++; $display("FAIL rnd_dcnt got=%0d exp=%0d", div_stall_cnt, pd); end
      end
`endif
      tick();
    end
    clr();
    rst_n = 1;
    tick();
  endtask

  initial begin
    clr();
    rst_n = 0;
    #1;
    test_reset();
    test_fwd_basic();
    test_r0();
    test_load_use();
    test_div();
    test_flush();
    test_reset_mid_div();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
